// File: rtl/ct_ifu_sfp_tbl.sv
// Store-forward prediction table: tagged entries with saturating confidence
// counters, trained by write requests and queried by a registered lookup.
module ct_ifu_sfp_tbl #(
  parameter int unsigned ENTRY_NUM = 8,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned HI_PC_W   = 8,
  parameter int unsigned PC_W      = 12
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst_b,
  input  logic               cp0_ifu_nsfe,
  input  logic               sfp_vl_pred_en,
  input  logic               rtu_ifu_chgflw_vld,
  input  logic               sfp_flush,
  input  logic               wr_vld,
  input  logic [3:0]         wr_op,
  input  logic               wr_type,
  input  logic [HI_PC_W-1:0] wr_hi_pc,
  input  logic [PC_W-1:0]    wr_sf_pc,
  input  logic [PC_W-1:0]    wr_bar_pc,
  input  logic               lkup_vld,
  input  logic [HI_PC_W-1:0] lkup_hi_pc,
  input  logic [PC_W-1:0]    lkup_sf_pc,
  output logic               lkup_hit,
  output logic [PC_W-1:0]    lkup_bar_pc,
  output logic [CNT_W-1:0]   lkup_cnt,
  output logic               lkup_type,
  output logic               lkup_pred,
  output logic               tbl_full
);

  localparam int unsigned PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Entry storage
  logic [ENTRY_NUM-1:0] valid_q, valid_d;
  logic [ENTRY_NUM-1:0] type_q, type_d;
  logic [ENTRY_NUM-1:0] miss_q, miss_d;
  logic [HI_PC_W-1:0]   hi_pc_q  [ENTRY_NUM];
  logic [HI_PC_W-1:0]   hi_pc_d  [ENTRY_NUM];
  logic [PC_W-1:0]      sf_pc_q  [ENTRY_NUM];
  logic [PC_W-1:0]      sf_pc_d  [ENTRY_NUM];
  logic [PC_W-1:0]      bar_pc_q [ENTRY_NUM];
  logic [PC_W-1:0]      bar_pc_d [ENTRY_NUM];
  logic [CNT_W-1:0]     cnt_q    [ENTRY_NUM];
  logic [CNT_W-1:0]     cnt_d    [ENTRY_NUM];

  logic [PTR_W-1:0]     vptr_q, vptr_d;

  // Lookup result registers
  logic                 lkup_hit_q, lkup_hit_d;
  logic [PC_W-1:0]      lkup_bar_q, lkup_bar_d;
  logic [CNT_W-1:0]     lkup_cnt_q, lkup_cnt_d;
  logic                 lkup_type_q, lkup_type_d;
  logic                 lkup_pred_q, lkup_pred_d;

  logic                 en;
  logic                 op_onehot;
  logic                 wr_act;
  logic                 alloc_new;
  logic [ENTRY_NUM-1:0] wr_match;
  logic [ENTRY_NUM-1:0] lk_match;
  logic [ENTRY_NUM-1:0] wr_sel;
  logic [ENTRY_NUM-1:0] gate_en;
  logic [PTR_W-1:0]     free_idx;
  logic [PTR_W-1:0]     lk_idx;
  logic [PTR_W-1:0]     alloc_idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  assign tbl_full = &valid_q;

  // Tag compare for training writes and lookups
  always_comb begin
    wr_match = '0;
    lk_match = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      wr_match[i] = valid_q[i] & (type_q[i] == wr_type) &
                    (hi_pc_q[i] == wr_hi_pc) & (sf_pc_q[i] == wr_sf_pc);
      lk_match[i] = valid_q[i] & (hi_pc_q[i] == lkup_hi_pc) &
                    (sf_pc_q[i] == lkup_sf_pc);
    end
  end

  // Lowest-index free entry and lowest-index lookup match
  always_comb begin
    free_idx = '0;
    lk_idx   = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = PTR_W'(i);
      if (lk_match[i]) lk_idx = PTR_W'(i);
    end
  end

  // Write qualification, allocation target and per-entry gate enable
  always_comb begin
    en        = cp0_ifu_nsfe | sfp_vl_pred_en;
    op_onehot = (wr_op == 4'b1000) | (wr_op == 4'b0100) |
                (wr_op == 4'b0010) | (wr_op == 4'b0001);
    wr_act    = wr_vld & en & ~sfp_flush & op_onehot;
    alloc_new = wr_act & ~(|wr_match) & wr_op[1];
    alloc_idx = tbl_full ? vptr_q : free_idx;
    wr_sel    = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      wr_sel[i] = wr_act & (wr_match[i] | (alloc_new & (alloc_idx == PTR_W'(i))));
    end
    gate_en   = wr_sel | {ENTRY_NUM{sfp_flush}};
  end

  // Entry next-state: flush, match update or fresh allocation
  always_comb begin
    valid_d  = valid_q;
    type_d   = type_q;
    miss_d   = miss_q;
    hi_pc_d  = hi_pc_q;
    sf_pc_d  = sf_pc_q;
    bar_pc_d = bar_pc_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (sfp_flush) begin
        valid_d[i] = 1'b0;
      end else if (wr_sel[i]) begin
        if (wr_match[i]) begin
          if (wr_op[3]) begin
            cnt_d[i] = '0;
          end else if (wr_op[2]) begin
            cnt_d[i] = (type_q[i] && (cnt_q[i] == CNT_ONE)) ? '0 : sat_inc(cnt_q[i]);
          end else if (wr_op[1]) begin
            cnt_d[i]    = CNT_ONE;
            bar_pc_d[i] = wr_bar_pc;
            miss_d[i]   = wr_type;
          end else begin
            cnt_d[i] = (miss_q[i] && rtu_ifu_chgflw_vld) ? sat_inc(cnt_q[i])
                                                          : sat_dec(cnt_q[i]);
          end
        end else begin
          valid_d[i]  = 1'b1;
          type_d[i]   = wr_type;
          hi_pc_d[i]  = wr_hi_pc;
          sf_pc_d[i]  = wr_sf_pc;
          bar_pc_d[i] = wr_bar_pc;
          cnt_d[i]    = CNT_ONE;
          miss_d[i]   = wr_type & wr_op[1];
        end
      end
    end
  end

  // Victim pointer moves only when an allocation evicts a valid entry
  always_comb begin
    vptr_d = vptr_q;
    if (alloc_new && tbl_full) vptr_d = vptr_q + PTR_W'(1);
  end

  // Lookup result: flush clears hit, disabled predictor holds everything
  always_comb begin
    lkup_hit_d  = lkup_hit_q;
    lkup_bar_d  = lkup_bar_q;
    lkup_cnt_d  = lkup_cnt_q;
    lkup_type_d = lkup_type_q;
    lkup_pred_d = lkup_pred_q;
    if (sfp_flush) begin
      lkup_hit_d  = 1'b0;
      lkup_pred_d = 1'b0;
    end else if (en) begin
      lkup_hit_d  = lkup_vld & (|lk_match);
      lkup_pred_d = lkup_hit_d & cnt_q[lk_idx][CNT_W-1];
      if (lkup_hit_d) begin
        lkup_bar_d  = bar_pc_q[lk_idx];
        lkup_cnt_d  = cnt_q[lk_idx];
        lkup_type_d = type_q[lk_idx];
      end
    end
  end

  // Entry registers, each loaded only when its gate enable is active
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      valid_q <= '0;
      type_q  <= '0;
      miss_q  <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        hi_pc_q[i]  <= '0;
        sf_pc_q[i]  <= '0;
        bar_pc_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (gate_en[i]) begin
          valid_q[i]  <= valid_d[i];
          type_q[i]   <= type_d[i];
          miss_q[i]   <= miss_d[i];
          hi_pc_q[i]  <= hi_pc_d[i];
          sf_pc_q[i]  <= sf_pc_d[i];
          bar_pc_q[i] <= bar_pc_d[i];
          cnt_q[i]    <= cnt_d[i];
        end
      end
    end
  end

  // Victim pointer and lookup output registers
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vptr_q      <= '0;
      lkup_hit_q  <= 1'b0;
      lkup_bar_q  <= '0;
      lkup_cnt_q  <= '0;
      lkup_type_q <= 1'b0;
      lkup_pred_q <= 1'b0;
    end else begin
      vptr_q      <= vptr_d;
      lkup_hit_q  <= lkup_hit_d;
      lkup_bar_q  <= lkup_bar_d;
      lkup_cnt_q  <= lkup_cnt_d;
      lkup_type_q <= lkup_type_d;
      lkup_pred_q <= lkup_pred_d;
    end
  end

  assign lkup_hit    = lkup_hit_q;
  assign lkup_bar_pc = lkup_bar_q;
  assign lkup_cnt    = lkup_cnt_q;
  assign lkup_type   = lkup_type_q;
  assign lkup_pred   = lkup_pred_q;

endmodule

// File: tb/tb_ct_ifu_sfp_tbl.sv
// Bench for ct_ifu_sfp_tbl: directed scenarios plus random traffic, with
// a queue-based scoreboard fed by an abstract table model.
module tb_ct_ifu_sfp_tbl;

  localparam int N    = 8;
  localparam int CMAX = 3;
  localparam int HALF = 2;

  logic        clk;
  logic        rst_n;
  logic        cp0_ifu_nsfe, sfp_vl_pred_en, rtu_ifu_chgflw_vld, sfp_flush;
  logic        wr_vld, wr_type, lkup_vld;
  logic [3:0]  wr_op;
  logic [7:0]  wr_hi_pc, lkup_hi_pc;
  logic [11:0] wr_sf_pc, wr_bar_pc, lkup_sf_pc;
  logic        lkup_hit, lkup_type, lkup_pred, tbl_full;
  logic [11:0] lkup_bar_pc;
  logic [1:0]  lkup_cnt;

  ct_ifu_sfp_tbl #(.ENTRY_NUM(8), .CNT_W(2), .HI_PC_W(8), .PC_W(12)) dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (rst_n),
    .cp0_ifu_nsfe       (cp0_ifu_nsfe),
    .sfp_vl_pred_en     (sfp_vl_pred_en),
    .rtu_ifu_chgflw_vld (rtu_ifu_chgflw_vld),
    .sfp_flush          (sfp_flush),
    .wr_vld             (wr_vld),
    .wr_op              (wr_op),
    .wr_type            (wr_type),
    .wr_hi_pc           (wr_hi_pc),
    .wr_sf_pc           (wr_sf_pc),
    .wr_bar_pc          (wr_bar_pc),
    .lkup_vld           (lkup_vld),
    .lkup_hi_pc         (lkup_hi_pc),
    .lkup_sf_pc         (lkup_sf_pc),
    .lkup_hit           (lkup_hit),
    .lkup_bar_pc        (lkup_bar_pc),
    .lkup_cnt           (lkup_cnt),
    .lkup_type          (lkup_type),
    .lkup_pred          (lkup_pred),
    .tbl_full           (tbl_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Abstract model of the table
  bit mv [N];
  bit mt [N];
  bit mm [N];
  int mh [N];
  int ms [N];
  int mb [N];
  int mc [N];
  int mptr;
  bit m_hit, m_typ, m_pred;
  int m_bar, m_cnt;

  typedef struct {
    int due;
    bit hit;
    int bar;
    int cnt;
    bit typ;
    bit pred;
    bit full;
  } rec_t;

  rec_t q[$];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mt[i] = 0; mm[i] = 0; mh[i] = 0; ms[i] = 0; mb[i] = 0; mc[i] = 0;
    end
    mptr = 0; m_hit = 0; m_typ = 0; m_pred = 0; m_bar = 0; m_cnt = 0;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < N; i++) if (!mv[i]) return 0;
    return 1;
  endfunction

  function automatic void model(input bit en, input bit chg, input bit fl, input bit wv,
                                input logic [3:0] op, input bit ty, input int hi,
                                input int sf, input int bar, input bit lv,
                                input int lhi, input int lsf);
    int f;
    int idx;
    // lookup sees the table before this cycle's write
    if (fl) begin
      m_hit = 0; m_pred = 0;
    end else if (en) begin
      f = -1;
      for (int i = 0; i < N; i++)
        if (f < 0 && mv[i] && mh[i] == lhi && ms[i] == lsf) f = i;
      m_hit = lv && (f >= 0);
      if (m_hit) begin
        m_bar = mb[f]; m_cnt = mc[f]; m_typ = mt[f];
      end
      m_pred = m_hit && (m_cnt >= HALF);
    end
    if (fl) begin
      for (int i = 0; i < N; i++) mv[i] = 0;
    end else if (en && wv && (op == 4'd1 || op == 4'd2 || op == 4'd4 || op == 4'd8)) begin
      f = -1;
      for (int i = 0; i < N; i++)
        if (mv[i] && mt[i] == ty && mh[i] == hi && ms[i] == sf) f = i;
      if (f >= 0) begin
        case (op)
          4'd8: mc[f] = 0;
          4'd4: mc[f] = (mt[f] && mc[f] == 1) ? 0 : ((mc[f] < CMAX) ? mc[f] + 1 : CMAX);
          4'd2: begin mc[f] = 1; mb[f] = bar; mm[f] = ty; end
          default: begin
            if (mm[f] && chg) mc[f] = (mc[f] < CMAX) ? mc[f] + 1 : CMAX;
            else              mc[f] = (mc[f] > 0) ? mc[f] - 1 : 0;
          end
        endcase
      end else if (op == 4'd2) begin
        idx = -1;
        for (int i = N - 1; i >= 0; i--) if (!mv[i]) idx = i;
        if (idx < 0) begin
          idx = mptr;
          mptr = (mptr + 1) % N;
        end
        mv[idx] = 1; mt[idx] = ty; mh[idx] = hi; ms[idx] = sf; mb[idx] = bar;
        mc[idx] = 1; mm[idx] = ty;
      end
    end
  endfunction

  // One clock of stimulus; expected response is queued for the monitor
  task automatic step(input bit a, input bit b, input bit chg, input bit fl, input bit wv,
                      input logic [3:0] op, input bit ty, input int hi, input int sf,
                      input int bar, input bit lv, input int lhi, input int lsf);
    rec_t r;
    cp0_ifu_nsfe = a; sfp_vl_pred_en = b; rtu_ifu_chgflw_vld = chg; sfp_flush = fl;
    wr_vld = wv; wr_op = op; wr_type = ty;
    wr_hi_pc = 8'(hi); wr_sf_pc = 12'(sf); wr_bar_pc = 12'(bar);
    lkup_vld = lv; lkup_hi_pc = 8'(lhi); lkup_sf_pc = 12'(lsf);
    model(a | b, chg, fl, wv, op, ty, hi, sf, bar, lv, lhi, lsf);
    r.due = cyc + 1; r.hit = m_hit; r.bar = m_bar; r.cnt = m_cnt; r.typ = m_typ;
    r.pred = m_pred; r.full = model_full();
    q.push_back(r);
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] op, input bit ty, input int hi, input int sf, input int bar);
    step(1, 0, 0, 0, 1, op, ty, hi, sf, bar, 0, 0, 0);
  endtask

  task automatic lk(input int hi, input int sf);
    step(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1, hi, sf);
  endtask

  task automatic wr_lk(input logic [3:0] op, input bit chg, input int hi, input int sf);
    step(1, 0, chg, 0, 1, op, 0, hi, sf, 0, 1, hi, sf);
  endtask

  // Monitor: compares each registered response against its queued expectation
  always @(negedge clk) begin
    rec_t r;
    if (rst_n) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        r = q.pop_front();
        chk("stale_rec", r.due, cyc);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        r = q.pop_front();
        chk("sb_hit",  int'(lkup_hit),    int'(r.hit));
        chk("sb_bar",  int'(lkup_bar_pc), r.bar);
        chk("sb_cnt",  int'(lkup_cnt),    r.cnt);
        chk("sb_type", int'(lkup_type),   int'(r.typ));
        chk("sb_pred", int'(lkup_pred),   int'(r.pred));
        chk("sb_full", int'(tbl_full),    int'(r.full));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got %0d expected %0d", cyc, 0);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] op;
    int         r;
    bit         a, b;

    rst_n = 1'b0;
    cp0_ifu_nsfe = 0; sfp_vl_pred_en = 0; rtu_ifu_chgflw_vld = 0; sfp_flush = 0;
    wr_vld = 0; wr_op = 0; wr_type = 0; wr_hi_pc = 0; wr_sf_pc = 0; wr_bar_pc = 0;
    lkup_vld = 0; lkup_hi_pc = 0; lkup_sf_pc = 0;
    model_reset();
    #23;
    chk("rst_hit",  int'(lkup_hit), 0);
    chk("rst_full", int'(tbl_full), 0);
    chk("rst_bar",  int'(lkup_bar_pc), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Allocation then lookup
    wr(4'b0010, 0, 'h12, 'h345, 'hABC);
    lk('h12, 'h345);
    chk("alloc_hit",  int'(lkup_hit), 1);
    chk("alloc_bar",  int'(lkup_bar_pc), 'hABC);
    chk("alloc_cnt",  int'(lkup_cnt), 1);
    chk("alloc_pred", int'(lkup_pred), 0);

    // Increments with same-cycle lookup return pre-write counter
    wr_lk(4'b0100, 0, 'h12, 'h345); chk("inc1_pre", int'(lkup_cnt), 1);
    wr_lk(4'b0100, 0, 'h12, 'h345); chk("inc2_pre", int'(lkup_cnt), 2);
    wr_lk(4'b0100, 0, 'h12, 'h345); chk("inc3_pre", int'(lkup_cnt), 3);
    lk('h12, 'h345);
    chk("inc_sat", int'(lkup_cnt), 3);
    chk("inc_pred", int'(lkup_pred), 1);
    wr_lk(4'b0001, 0, 'h12, 'h345); chk("dec1_pre", int'(lkup_cnt), 3);
    wr_lk(4'b0001, 0, 'h12, 'h345); chk("dec2_pre", int'(lkup_cnt), 2);
    wr_lk(4'b0001, 0, 'h12, 'h345); chk("dec3_pre", int'(lkup_cnt), 1);
    wr_lk(4'b0001, 0, 'h12, 'h345); chk("dec4_pre", int'(lkup_cnt), 0);
    lk('h12, 'h345);
    chk("dec_floor", int'(lkup_cnt), 0);
    chk("dec_pred",  int'(lkup_pred), 0);

    // Type-1 entries: inc at cnt 1 clears, dec with change-of-flow rises
    wr(4'b0010, 1, 'h20, 'h111, 'h055);
    wr(4'b0100, 1, 'h20, 'h111, 0);
    lk('h20, 'h111);
    chk("t1_inc_cnt", int'(lkup_cnt), 0);
    chk("t1_type",    int'(lkup_type), 1);
    wr(4'b0010, 1, 'h21, 'h222, 'h066);
    step(1, 0, 1, 0, 1, 4'b0001, 1, 'h21, 'h222, 0, 0, 0, 0);
    lk('h21, 'h222);
    chk("t1_dec_chg", int'(lkup_cnt), 2);

    // Fill, replace and wrap the victim pointer
    step(1, 0, 0, 1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) wr(4'b0010, 0, 'h40 + i, 'h100 + i, i);
    chk("fill_full", int'(tbl_full), 1);
    chk("fill_vptr", int'(dut.vptr_q), 0);
    wr(4'b0010, 0, 'h48, 'h108, 8);
    chk("repl_vptr", int'(dut.vptr_q), 1);
    lk('h40, 'h100);
    chk("repl_evict", int'(lkup_hit), 0);
    for (int i = 9; i < 17; i++) wr(4'b0010, 0, 'h40 + i, 'h100 + i, i);
    chk("wrap_vptr", int'(dut.vptr_q), 1);
    chk("wrap_model", int'(dut.vptr_q), mptr);

    // Disabled predictor ignores writes
    step(0, 0, 0, 0, 1, 4'b0010, 0, 'h77, 'h777, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4'b0100, 0, 'h49, 'h109, 0, 0, 0, 0);
    lk('h77, 'h777);
    chk("dis_alloc", int'(lkup_hit), 0);
    chk("dis_vptr",  int'(dut.vptr_q), 1);
    lk('h49, 'h109);
    chk("dis_cnt", int'(lkup_cnt), 1);

    // Flush beats a same-cycle alloc and lookup
    step(1, 0, 0, 1, 1, 4'b0010, 0, 'h78, 'h778, 2, 1, 'h49, 'h109);
    chk("flush_full", int'(tbl_full), 0);
    chk("flush_hit",  int'(lkup_hit), 0);
    lk('h78, 'h778);
    chk("flush_alloc", int'(lkup_hit), 0);

    // Random traffic over a small tag space
    for (int n = 0; n < 2000; n++) begin
      r = int'($urandom_range(0, 99));
      a = 1'b1;
      b = 1'($urandom_range(0, 1));
      if (!m_hit && r < 10) begin a = 1'b0; b = 1'b0; end
      else if (r < 30) a = 1'b0;
      r = int'($urandom_range(0, 9));
      if (r < 4)      op = 4'b0010;
      else if (r < 8) op = 4'(1 << $urandom_range(0, 3));
      else            op = 4'($urandom_range(0, 15));
      step(a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           op, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
    end

    // Reset during an in-flight lookup
    wr(4'b0010, 0, 'h5A, 'h5A5, 'h3C3);
    lk('h5A, 'h5A5);
    chk("pre_rst_hit", int'(lkup_hit), 1);
    lkup_vld = 1'b1;
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("rst_mid_hit",  int'(lkup_hit), 0);
    chk("rst_mid_full", int'(tbl_full), 0);
    chk("rst_mid_bar",  int'(lkup_bar_pc), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("post_rst_hit", int'(lkup_hit), 0);
    chk("post_rst_vptr", int'(dut.vptr_q), 0);
    lk('h5A, 'h5A5);
    chk("post_rst_lk", int'(lkup_hit), 0);
    step(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("sb_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ct_ifu_sfp_tbl.md
CT_IFU_SFP_TBL -- requirements
Module: ct_ifu_sfp_tbl

Interface
REQ-001 SHALL have parameter ENTRY_NUM, default 8, number of entries (power of 2, 2..32).
REQ-002 SHALL have parameter CNT_W, default 2, saturating counter width (2..4).
REQ-003 SHALL have parameter HI_PC_W, default 8, high PC tag width.
REQ-004 SHALL have parameter PC_W, default 12, store/barrier PC field width.
REQ-005 SHALL have port forever_cpuclk, input, 1, the single clock, rising edge.
REQ-006 SHALL have port cpurst_b, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port cp0_ifu_nsfe, input, 1, predictor enable.
REQ-008 SHALL have port sfp_vl_pred_en, input, 1, alternate enable.
REQ-009 SHALL have port rtu_ifu_chgflw_vld, input, 1, retire change-of-flow.
REQ-010 SHALL have port sfp_flush, input, 1, invalidate all entries.
REQ-011 SHALL have port wr_vld, input, 1, training write request.
REQ-012 SHALL have port wr_op, input, 4, one-hot op: [3] clear, [2] inc, [1] alloc, [0] dec.
REQ-013 SHALL have port wr_type, input, 1, entry type.
REQ-014 SHALL have ports wr_hi_pc (HI_PC_W), wr_sf_pc (PC_W), wr_bar_pc (PC_W), input, training tags.
REQ-015 SHALL have port lkup_vld, input, 1, lookup request.
REQ-016 SHALL have ports lkup_hi_pc (HI_PC_W), lkup_sf_pc (PC_W), input, lookup tags.
REQ-017 SHALL have port lkup_hit, output, 1, registered hit.
REQ-018 SHALL have ports lkup_bar_pc (PC_W), lkup_cnt (CNT_W), lkup_type (1), output, registered hit payload.
REQ-019 SHALL have port lkup_pred, output, 1, registered confident prediction.
REQ-020 SHALL have port tbl_full, output, 1, all entries valid.

Function
REQ-021 SHALL define en = cp0_ifu_nsfe | sfp_vl_pred_en; with en=0, no entry state, victim pointer, or lookup register changes (sfp_flush excepted).
REQ-022 SHALL, per entry, hold valid, type, hi_pc, sf_pc, bar_pc, cnt[CNT_W], miss_state.
REQ-023 SHALL define write match = valid & type==wr_type & hi_pc==wr_hi_pc & sf_pc==wr_sf_pc; at most one entry matches by construction.
REQ-024 SHALL, on wr_vld & en & match, update the matching entry: clear -> cnt=0; inc -> cnt=0 if type & cnt==1, else saturating +1; alloc -> cnt=1, bar_pc=wr_bar_pc; dec -> saturating +1 if miss_state & rtu_ifu_chgflw_vld, else saturating -1.
REQ-025 SHALL, on wr_vld & en & no match & wr_op[1], allocate the lowest-index invalid entry, or, if tbl_full, the entry at victim pointer; it writes all tags, bar_pc, valid=1, cnt=1, and miss_state=wr_type & wr_op[1].
REQ-026 SHALL ignore no-match writes with op other than alloc, and writes whose wr_op is not one-hot.
REQ-027 SHALL advance the log2(ENTRY_NUM)-bit victim pointer by 1 (wrapping ENTRY_NUM-1 -> 0) only on an allocation that replaces a valid entry.
REQ-028 SHALL set miss_state on match-alloc to wr_type, and leave it unchanged on other ops.
REQ-029 SHALL saturate counters at 0 and 2^CNT_W-1; no wrap.
REQ-030 SHALL compute lookup match = valid & hi_pc==lkup_hi_pc & sf_pc==lkup_sf_pc, and register the result one cycle after lkup_vld & en: lkup_hit, and the payload of the lowest-index matching entry.
REQ-031 SHALL drive lkup_pred = lkup_hit & cnt MSB set.
REQ-032 SHALL clear lkup_hit in the cycle after a lookup that misses or when lkup_vld=0; payload holds its last value.
REQ-033 SHALL, for a same-cycle write and lookup to the same entry, return pre-write state to the lookup.
REQ-034 SHALL, on sfp_flush, clear all valid bits and lkup_hit next cycle; flush has priority over same-cycle write and lookup; counters, tags, and victim pointer retain their values.
REQ-035 SHALL drive tbl_full = AND of valid bits, combinationally.
REQ-036 SHALL use an entry-level clock gate whose enable is write-select | flush.

Reset
REQ-037 SHALL, while cpurst_b=0, asynchronously clear all valid, type, tags, bar_pc, cnt, miss_state, victim pointer, lkup_hit, and payload outputs; tbl_full=0.
REQ-038 SHALL accept requests from the first rising edge after cpurst_b deasserts; an in-flight lookup during reset is dropped.

Verification
REQ-039 Bench SHALL cover: alloc with hi=0x12, sf=0x345, bar=0xABC, type=0; next-cycle lookup of the same tags -> lkup_hit=1, lkup_bar_pc=0xABC, lkup_cnt=1, lkup_pred=0.
REQ-040 Bench SHALL cover: three inc on that entry -> cnt 2, 3, 3 (saturated), and lookup -> lkup_pred=1; four dec -> 2, 1, 0, 0.
REQ-041 Bench SHALL cover: type=1 entry at cnt=1 with inc -> cnt=0; type=1 alloc, then dec with rtu_ifu_chgflw_vld=1 -> cnt=2.
REQ-042 Bench SHALL cover: 9 distinct allocs with ENTRY_NUM=8 -> tbl_full=1 after the 8th; the 9th replaces entry 0, victim pointer becomes 1; after 8 further replacements the pointer wraps to 1.
REQ-043 Bench SHALL cover: cp0_ifu_nsfe=0 and sfp_vl_pred_en=0 with a write -> no state change; sfp_flush with a same-cycle alloc -> all entries invalid, tbl_full=0.
REQ-044 Bench SHALL cover: cpurst_b asserted mid-lookup -> lkup_hit=0 immediately, and all entries invalid after release.
